// File: rtl/cmos_cfg_pkg.sv
// rtl/cmos_cfg_pkg.sv - shared types and constants for the sensor configuration sequencer
// Purpose: FSM state encoding, LUT entry field positions, default soft-reset
//          register address and the delay preload helper.
// Ports:   none (package).
package cmos_cfg_pkg;

  localparam int CNT_W    = 20;
  localparam int ADDR_MSB = 23;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;

  localparam logic [15:0] DEFAULT_SOFT_RST_ADDR = 16'h0103;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INIT_WAIT = 3'd1,
    ST_LOAD      = 3'd2,
    ST_REQ       = 3'd3,
    ST_POST_DLY  = 3'd4,
    ST_NEXT      = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERROR     = 3'd7
  } cfg_state_t;

  // A wait of N cycles is loaded as N-1 so the zero flag closes the Nth cycle.
  // A requested wait of 0 degenerates to a single cycle.
  function automatic logic [CNT_W-1:0] dly_preload(input logic [CNT_W-1:0] cycles);
    return (cycles == '0) ? '0 : cycles - CNT_W'(1);
  endfunction

endpackage

// File: rtl/cfg_delay_cnt.sv
// rtl/cfg_delay_cnt.sv - loadable down-counter with zero flag
// Purpose: single wait counter reused for power-up, post-soft-reset and
//          response-timeout waits.
// Ports:   clk, rst (sync, active high), load (take load_val this cycle),
//          load_val (preload value), zero (count has reached zero).
module cfg_delay_cnt
  import cmos_cfg_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Saturates at zero so the flag stays set until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// rtl/i2c_cfg_sequencer.sv - walks a sensor register LUT and issues I2C writes
// Purpose: after a power-up wait, writes every {addr16, data8} LUT entry through
//          a byte-level I2C master, retrying NACK/timeout, pausing after the
//          soft-reset register, and reporting cfg_done or cfg_error.
// Ports:   clk, rst (sync, active high), start (restart pulse),
//          lut_index/lut_data/lut_size (LUT read port, data combinational),
//          i2c_req/i2c_addr/i2c_wdata/i2c_done/i2c_nack (master handshake),
//          busy, cfg_done, cfg_error, err_index (status).
module i2c_cfg_sequencer
  import cmos_cfg_pkg::*;
#(
  parameter logic [19:0] INIT_DELAY    = 20'd1000000,
  parameter logic [19:0] RST_DELAY     = 20'd100000,
  parameter logic [15:0] SOFT_RST_ADDR = DEFAULT_SOFT_RST_ADDR,
  parameter int unsigned MAX_RETRY     = 3,
  parameter logic [15:0] RSP_TIMEOUT   = 16'd50000,
  parameter bit          AUTO_START    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  lut_index,
  input  logic [23:0] lut_data,
  input  logic [7:0]  lut_size,
  output logic        i2c_req,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_wdata,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [7:0]  err_index
);

  cfg_state_t       state, state_nxt;
  logic [7:0]       retry_cnt;
  logic             dly_load, dly_zero;
  logic [CNT_W-1:0] dly_val;
  logic             rsp_ok, rsp_fail, can_retry;

  // In REQ the shared counter holds the response timeout; a done pulse in the
  // same cycle as expiry still counts as a response.
  assign rsp_ok    = i2c_done && !i2c_nack;
  assign rsp_fail  = (i2c_done && i2c_nack) || (!i2c_done && dly_zero);
  assign can_retry = {24'd0, retry_cnt} < MAX_RETRY;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (AUTO_START || start) state_nxt = ST_INIT_WAIT;
      ST_INIT_WAIT: if (dly_zero) state_nxt = (lut_size == 8'd0) ? ST_DONE : ST_LOAD;
      ST_LOAD:      state_nxt = ST_REQ;
      ST_REQ: begin
        if (rsp_ok) begin
          state_nxt = (i2c_addr == SOFT_RST_ADDR) ? ST_POST_DLY : ST_NEXT;
        end else if (rsp_fail) begin
          state_nxt = can_retry ? ST_LOAD : ST_ERROR;
        end
      end
      ST_POST_DLY:  if (dly_zero) state_nxt = ST_NEXT;
      // The NEXT cycle gives the external LUT a full cycle on the new index.
      ST_NEXT:      state_nxt = (lut_index == lut_size - 8'd1) ? ST_DONE : ST_LOAD;
      ST_DONE,
      ST_ERROR:     if (start) state_nxt = ST_INIT_WAIT;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    i2c_req   = (state == ST_REQ);
    busy      = state inside {ST_INIT_WAIT, ST_LOAD, ST_REQ, ST_POST_DLY, ST_NEXT};
    cfg_done  = (state == ST_DONE);
    cfg_error = (state == ST_ERROR);
  end

  // Load the wait counter on entry to each waiting state.
  always_comb begin
    dly_load = 1'b0;
    dly_val  = '0;
    if (state_nxt != state) begin
      case (state_nxt)
        ST_INIT_WAIT: begin
          dly_load = 1'b1;
          dly_val  = dly_preload(INIT_DELAY);
        end
        ST_REQ: begin
          dly_load = 1'b1;
          dly_val  = dly_preload(CNT_W'(RSP_TIMEOUT));
        end
        ST_POST_DLY: begin
          dly_load = 1'b1;
          dly_val  = dly_preload(RST_DELAY);
        end
        default: ;
      endcase
    end
  end

  cfg_delay_cnt #(.W(CNT_W)) u_dly (
    .clk      (clk),
    .rst      (rst),
    .load     (dly_load),
    .load_val (dly_val),
    .zero     (dly_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      lut_index <= '0;
      i2c_addr  <= '0;
      i2c_wdata <= '0;
      err_index <= '0;
      retry_cnt <= '0;
    end else begin
      if (state_nxt == ST_INIT_WAIT && state != ST_INIT_WAIT) begin
        lut_index <= '0;
        retry_cnt <= '0;
      end
      if (state == ST_LOAD) begin
        i2c_addr  <= lut_data[ADDR_MSB:ADDR_LSB];
        i2c_wdata <= lut_data[DATA_MSB:0];
      end
      if (state == ST_REQ) begin
        if (rsp_ok) begin
          retry_cnt <= '0;
        end else if (rsp_fail && can_retry) begin
          retry_cnt <= retry_cnt + 8'd1;
        end
      end
      if (state == ST_NEXT && state_nxt == ST_LOAD) begin
        lut_index <= lut_index + 8'd1;
      end
      if (state_nxt == ST_ERROR && state != ST_ERROR) begin
        err_index <= lut_index;
      end
    end
  end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb/tb_i2c_cfg_sequencer.sv - self-checking bench for i2c_cfg_sequencer
module tb_i2c_cfg_sequencer;

  localparam int          INIT_D   = 10;
  localparam int          RST_D    = 20;
  localparam int          MAXR     = 3;
  localparam int          TOUT     = 16;
  localparam logic [15:0] SOFT_RST = 16'h0103;

  localparam int R_ACK    = 0;
  localparam int R_NACK   = 1;
  localparam int R_SILENT = 2;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } xact_t;

  typedef struct {
    int kind;
    int lat;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  lut_index;
  logic [23:0] lut_data;
  logic [7:0]  lut_size;
  logic        i2c_req;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_wdata;
  logic        i2c_done;
  logic        i2c_nack;
  logic        busy;
  logic        cfg_done;
  logic        cfg_error;
  logic [7:0]  err_index;

  logic [23:0] lut_mem [0:255];
  int          fails   [0:255];
  bit          silent  [0:255];

  xact_t exp_q[$];
  xact_t obs_q[$];
  resp_t plan_q[$];
  int    exp_end;
  int    exp_idx;
  bit    exp_err;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  string cur_case = "init";

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign lut_data = lut_mem[lut_index];

  i2c_cfg_sequencer #(
    .INIT_DELAY    (20'(INIT_D)),
    .RST_DELAY     (20'(RST_D)),
    .SOFT_RST_ADDR (SOFT_RST),
    .MAX_RETRY     (MAXR),
    .RSP_TIMEOUT   (16'(TOUT)),
    .AUTO_START    (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .lut_index (lut_index),
    .lut_data  (lut_data),
    .lut_size  (lut_size),
    .i2c_req   (i2c_req),
    .i2c_addr  (i2c_addr),
    .i2c_wdata (i2c_wdata),
    .i2c_done  (i2c_done),
    .i2c_nack  (i2c_nack),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .cfg_error (cfg_error),
    .err_index (err_index)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", cur_case, tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_lut_index", 32'(lut_index), 0);
    check("rst_i2c_req",   32'(i2c_req),   0);
    check("rst_i2c_addr",  32'(i2c_addr),  0);
    check("rst_i2c_wdata", 32'(i2c_wdata), 0);
    check("rst_busy",      32'(busy),      0);
    check("rst_cfg_done",  32'(cfg_done),  0);
    check("rst_cfg_error", 32'(cfg_error), 0);
    check("rst_err_index", 32'(err_index), 0);
  endtask

  // Random LUT of n entries that never hits the soft-reset address by chance.
  task automatic fill_lut(input int n);
    int a;
    for (int i = 0; i < 256; i++) begin
      a = int'($urandom_range(0, 65535));
      if (a[15:0] == SOFT_RST) a = a + 1;
      lut_mem[i] = {a[15:0], 8'($urandom)};
      fails[i]   = 0;
      silent[i]  = 1'b0;
    end
    lut_size = 8'(n);
  endtask

  // Reference model: expected write attempts with request-rise cycles, the
  // master's response to each attempt, and the final outcome.
  // t0 is the cycle at which the first request must rise.
  task automatic build(input int t0);
    int t, lat, d;
    bit fin;
    exp_q.delete();
    plan_q.delete();
    exp_err = 1'b0;
    exp_idx = 0;
    exp_end = t0 - 1;
    t       = t0;
    fin     = 1'b0;
    for (int i = 0; i < int'(lut_size) && !fin; i++) begin
      for (int a = 0; a <= MAXR; a++) begin
        lat = int'($urandom_range(1, 6));
        exp_q.push_back('{lut_mem[i][23:8], lut_mem[i][7:0], t});
        if (a < fails[i]) begin
          if (silent[i]) begin
            plan_q.push_back('{R_SILENT, 0});
            t = t + TOUT + 1;
          end else begin
            plan_q.push_back('{R_NACK, lat});
            t = t + lat + 2;
          end
          if (a == MAXR) begin
            exp_err = 1'b1;
            exp_idx = i;
            exp_end = t - 1;
            fin     = 1'b1;
          end
        end else begin
          plan_q.push_back('{R_ACK, lat});
          d = t + lat + ((lut_mem[i][23:8] == SOFT_RST) ? RST_D : 0);
          exp_end = d + 2;
          t       = d + 3;
          break;
        end
      end
    end
  endtask

  // Master model: answers each request according to the plan.
  task automatic serve();
    resp_t p;
    int    n, r;
    while (plan_q.size() > 0) begin
      p = plan_q.pop_front();
      n = 0;
      while (i2c_req !== 1'b1 && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (i2c_req !== 1'b1) begin
        check("req_rise_wait", 32'(i2c_req), 1);
        plan_q.delete();
        return;
      end
      r = cyc;
      obs_q.push_back('{i2c_addr, i2c_wdata, r});
      if (p.kind == R_SILENT) begin
        n = 0;
        while (i2c_req === 1'b1 && n < 400) begin
          @(negedge clk);
          n++;
        end
        check("timeout_width", 32'(cyc - r), TOUT);
      end else begin
        repeat (p.lat) @(negedge clk);
        i2c_done = 1'b1;
        i2c_nack = (p.kind == R_NACK);
        @(negedge clk);
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
      end
    end
  endtask

  task automatic pulse_start(output int s);
    s = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_busy",      32'(busy),      1);
    check("restart_cfg_done",  32'(cfg_done),  0);
    check("restart_cfg_error", 32'(cfg_error), 0);
    check("restart_lut_index", 32'(lut_index), 0);
  endtask

  task automatic run_case(input int s);
    int n, hi;
    build(s + INIT_D + 2);
    obs_q.delete();
    serve();
    n = 0;
    while (!(cfg_done === 1'b1 || cfg_error === 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("end_cycle", 32'(cyc), 32'(exp_end));
    check("cfg_done",  32'(cfg_done),  32'(!exp_err));
    check("cfg_error", 32'(cfg_error), 32'(exp_err));
    check("busy_end",  32'(busy), 0);
    if (exp_err) check("err_index", 32'(err_index), 32'(exp_idx));
    check("attempts", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("addr%0d", i), 32'(obs_q[i].addr), 32'(exp_q[i].addr));
      check($sformatf("data%0d", i), 32'(obs_q[i].data), 32'(exp_q[i].data));
      check($sformatf("rise%0d", i), 32'(obs_q[i].cyc),  32'(exp_q[i].cyc));
    end
    hi = 0;
    repeat (8) begin
      @(negedge clk);
      if (i2c_req === 1'b1) hi++;
    end
    check("idle_req", 32'(hi), 0);
  endtask

  initial begin
    int s, n;
    rst      = 1'b1;
    start    = 1'b0;
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    fill_lut(3);
    repeat (3) @(negedge clk);
    cur_case = "reset";
    check_reset_vals();

    // Auto-start after reset release, three plain writes.
    cur_case = "auto_plain";
    s = cyc;
    rst = 1'b0;
    run_case(s);

    // Restart from DONE; entry 0 is the soft reset, so a settle wait follows it.
    cur_case = "soft_reset";
    fill_lut(3);
    lut_mem[0] = {SOFT_RST, 8'h01};
    pulse_start(s);
    run_case(s);

    // Entry 1 NACKed twice then acked; a start pulse while busy is ignored.
    cur_case = "nack_retry";
    fill_lut(4);
    fails[1] = 2;
    pulse_start(s);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_case(s);

    // Entry 2 always NACKed: retries exhausted, abort at index 2.
    cur_case = "nack_abort";
    fill_lut(4);
    fails[2] = 9;
    pulse_start(s);
    run_case(s);

    // Restart from ERROR; master never answers entry 0.
    cur_case = "timeout_abort";
    fill_lut(2);
    fails[0]  = 9;
    silent[0] = 1'b1;
    pulse_start(s);
    run_case(s);

    // Empty LUT completes with no request.
    cur_case = "empty_lut";
    fill_lut(0);
    pulse_start(s);
    run_case(s);

    // Reset while a request is outstanding, then the automatic rerun.
    cur_case = "rst_in_req";
    fill_lut(2);
    pulse_start(s);
    n = 0;
    while (i2c_req !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_before_rst", 32'(i2c_req), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals();
    cur_case = "rerun_after_rst";
    fails[1] = int'($urandom_range(0, 2));
    s = cyc;
    rst = 1'b0;
    run_case(s);

    for (int k = 0; k < 4; k++) begin
      cur_case = $sformatf("rand%0d", k);
      fill_lut(int'($urandom_range(1, 5)));
      for (int i = 0; i < 8; i++) begin
        fails[i]  = ($urandom_range(0, 5) == 0) ? 4 : int'($urandom_range(0, 2));
        silent[i] = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 1) == 1)
        lut_mem[$urandom_range(0, int'(lut_size) - 1)] = {SOFT_RST, 8'h01};
      pulse_start(s);
      run_case(s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
